fetch_pc_gen: RTL
=================

# fetch_pc_gen

Parametrised fetch-address generator at the front of the fetch pipeline, between the exception/branch-resolution logic and the instruction cache. It holds the fetch PC and issues one fetch request at a time to the icache over a valid/ready handshake. It redirects on exceptions and branch mispredictions and follows branch-predictor targets. Responses belonging to squashed requests are marked for discard downstream, and those discards are counted for performance analysis.

## Interface
- ADDR_W, 32: fetch address width.
- FETCH_W, 2: instructions per fetch block; power of 2, range 1..8; FETCH_BYTES = 4*FETCH_W.
- RESET_VEC, 32'hbfc00000: PC after reset.
- CNT_W, 16: width of the kill counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_redirect  in  1  exception/eret redirect
- ex_target  in  ADDR_W  exception redirect target
- br_redirect  in  1  branch misprediction redirect
- br_taken  in  1  resolved direction of the mispredicted branch
- br_target  in  ADDR_W  resolved taken target
- br_pc  in  ADDR_W  PC of the mispredicted branch
- bp_valid  in  1  predictor hit for current pc
- bp_target  in  ADDR_W  predicted next fetch block address
- ibuf_full  in  1  instruction buffer cannot accept a block
- ic_req_valid  out  1  fetch request
- ic_req_addr  out  ADDR_W  fetch address (= pc)
- ic_req_ready  in  1  icache accepts request
- ic_resp_valid  in  1  icache returns data for the outstanding request
- ic_resp_drop  out  1  current response is stale; discard it
- pc  out  ADDR_W  current fetch PC
- kill_cnt  out  CNT_W  number of dropped responses, saturating

## Operation
- redirect = ex_redirect | br_redirect. Priority: rst > ex_redirect > br_redirect > request fire > hold.
- Redirect target:
  - ex_redirect: ex_target.
  - br_redirect with br_taken = 1: br_target.
  - br_redirect with br_taken = 0: br_pc + 8 (branch plus delay slot, independent of FETCH_W).
- Sequential next: (pc & ~(FETCH_BYTES-1)) + FETCH_BYTES, wrapping modulo 2^ADDR_W.
- Fire = ic_req_valid & ic_req_ready. On fire, pc <= bp_valid ? bp_target : sequential next.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one accepted request outstanding.
  - KILL: an outstanding request has been squashed.
- ic_req_valid = !rst & !redirect & !ibuf_full & (state==IDLE | (state==WAIT & ic_resp_valid & !ic_resp_drop)).
- ic_req_valid may deassert only because of redirect, ibuf_full or rst. The icache counts a request only on fire.
- Transitions:
  - IDLE: fire → WAIT; otherwise IDLE.
  - WAIT: redirect & !ic_resp_valid → KILL. ic_resp_valid → WAIT if fire, else IDLE. Otherwise WAIT.
  - KILL: ic_resp_valid → IDLE. Otherwise KILL, including on further redirects.
- ic_resp_drop = ic_resp_valid & (state==KILL | (state==WAIT & redirect)).
- kill_cnt increments on every ic_resp_drop and saturates at all-ones.
- Reset values: pc = RESET_VEC, state = IDLE, kill_cnt = 0, ic_req_valid = 0, ic_resp_drop = 0.

## Timing
- pc is registered; a redirect or fire in cycle N gives the new pc in cycle N+1.
- The request for a redirect target is issued no earlier than cycle N+1.
- At most one request is outstanding. Back-to-back fetch is possible when the response and the next fire coincide in the same cycle, giving 1 block/cycle at 1-cycle icache latency.
- Redirect with no request outstanding (IDLE): pc updates and no drop is generated.
- Redirect and ic_resp_valid in the same cycle while in WAIT: the response is dropped, state goes to IDLE, and pc takes the redirect target.
- rst asserted mid-operation (state WAIT or KILL): state goes to IDLE immediately. Any response arriving after reset is not flagged; the icache is reset by the same rst.
- ibuf_full suppresses new requests only. An outstanding response is still accepted and counted.

## Structure
- Shared package, fetch_pkg:
  - FSM state typedef (IDLE/WAIT/KILL).
  - RESET_VEC default.
  - Delay-slot offset constant 8.
- Sub-module fetch_redirect_mux: combinational priority/target select producing redirect and redirect_pc.
- FSM, pc register and counter stay in the top module.

## Test plan
- Reset: rst high 2 cycles then low, ic_req_ready=1 → pc=0xbfc00000, req valid in the first cycle after rst; with FETCH_W=2, pc sequence 0xbfc00000, 0xbfc00008, 0xbfc00010 under 1-cycle responses.
- Predictor: bp_valid=1, bp_target=0x80001000 on fire at pc=0xbfc00008 → next pc=0x80001000.
- Mispredict not-taken: br_redirect=1, br_taken=0, br_pc=0x80000100 while in WAIT, no response → pc=0x80000108 next cycle, state KILL; the next ic_resp_valid gives ic_resp_drop=1, kill_cnt=1, and no request in that cycle.
- Simultaneous events: ex_redirect (ex_target=0xbfc00380) and br_redirect in the same cycle as ic_resp_valid in WAIT → pc=0xbfc00380, drop=1, state IDLE.
- ibuf_full held 5 cycles in IDLE → ic_req_valid=0 and pc constant; after release, a request is issued at the same pc.
- Counter saturation and wrap: CNT_W=2 with 5 drops → kill_cnt=3. With ADDR_W=32 and pc=0xfffffff8, FETCH_W=2, a fire gives pc=0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL
    } fetch_state_t;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'hbfc00000;

    // Not-taken mispredict resumes after the branch and its delay slot.
    localparam int unsigned DELAY_SLOT_OFFSET = 8;

endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect priority and target select: exception beats branch mispredict.
module fetch_redirect_mux
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              br_redirect,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_pc,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc
);

    always_comb begin
        redirect = ex_redirect | br_redirect;
        if (ex_redirect)
            redirect_pc = ex_target;
        else if (br_taken)
            redirect_pc = br_target;
        else
            redirect_pc = br_pc + ADDR_W'(DELAY_SLOT_OFFSET);
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: one outstanding icache request, redirect handling and
// marking/counting of responses that belong to squashed requests.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 32,
    parameter int unsigned             FETCH_W   = 2,
    parameter logic [ADDR_W-1:0]       RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT),
    parameter int unsigned             CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              br_redirect,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic              bp_valid,
    input  logic [ADDR_W-1:0] bp_target,
    input  logic              ibuf_full,
    output logic              ic_req_valid,
    output logic [ADDR_W-1:0] ic_req_addr,
    input  logic              ic_req_ready,
    input  logic              ic_resp_valid,
    output logic              ic_resp_drop,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  kill_cnt
);

    localparam int unsigned       FETCH_BYTES = 4 * FETCH_W;
    localparam logic [ADDR_W-1:0] BLOCK_MASK  = ~ADDR_W'(FETCH_BYTES - 1);

    fetch_state_t      state;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] seq_pc;
    logic              fire;

    fetch_redirect_mux #(
        .ADDR_W(ADDR_W)
    ) u_redirect_mux (
        .ex_redirect(ex_redirect),
        .ex_target  (ex_target),
        .br_redirect(br_redirect),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .br_pc      (br_pc),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    always_comb begin
        seq_pc       = (pc & BLOCK_MASK) + ADDR_W'(FETCH_BYTES);
        ic_resp_drop = !rst && ic_resp_valid &&
                       (state == KILL || (state == WAIT && redirect));
        // A new request may go out in the same cycle the previous response lands.
        ic_req_valid = !rst && !redirect && !ibuf_full &&
                       (state == IDLE ||
                        (state == WAIT && ic_resp_valid && !ic_resp_drop));
        fire         = ic_req_valid && ic_req_ready;
        ic_req_addr  = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_VEC;
            kill_cnt <= '0;
        end else begin
            if (redirect)
                pc <= redirect_pc;
            else if (fire)
                pc <= bp_valid ? bp_target : seq_pc;

            if (ic_resp_drop && kill_cnt != '1)
                kill_cnt <= kill_cnt + CNT_W'(1);

            unique case (state)
                IDLE: if (fire) state <= WAIT;
                WAIT: begin
                    if (redirect && !ic_resp_valid)
                        state <= KILL;
                    else if (ic_resp_valid)
                        state <= fire ? WAIT : IDLE;
                end
                KILL: if (ic_resp_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
